// File: rtl/frame_buf_scheduler_if.sv
// Frame-event / buffer-address bus between the frame scheduler and its SDRAM write/read paths.
interface frame_buf_scheduler_if #(
    parameter int ADDR_W = 29
);
    logic              enable;
    logic              wr_frame_start;
    logic              wr_frame_done;
    logic              rd_frame_start;
    logic              wr_go;
    logic              wr_busy;
    logic [ADDR_W-1:0] wr_buf_addr;
    logic [1:0]        wr_buf_idx;
    logic              rd_valid;
    logic [ADDR_W-1:0] rd_buf_addr;
    logic [1:0]        rd_buf_idx;
    logic [15:0]       drop_cnt;
    logic [15:0]       repeat_cnt;

    modport master (
        output enable, wr_frame_start, wr_frame_done, rd_frame_start,
        input  wr_go, wr_busy, wr_buf_addr, wr_buf_idx,
        input  rd_valid, rd_buf_addr, rd_buf_idx, drop_cnt, repeat_cnt
    );

    modport slave (
        input  enable, wr_frame_start, wr_frame_done, rd_frame_start,
        output wr_go, wr_busy, wr_buf_addr, wr_buf_idx,
        output rd_valid, rd_buf_addr, rd_buf_idx, drop_cnt, repeat_cnt
    );
endinterface

// File: rtl/frame_buf_scheduler.sv
// Triple-buffer scheduler: the writer always gets a buffer (overwriting stale frames),
// the reader takes the newest completed frame or repeats the one it holds.
module frame_buf_scheduler #(
    parameter int                ADDR_W     = 29,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 29'h0100_0000,
    parameter logic [ADDR_W-1:0] BUF_STRIDE = 29'h0020_0000
) (
    input  logic           clk_100,
    input  logic           reset,
    frame_buf_scheduler_if.slave bus
);
    typedef enum logic [1:0] {FREE, WRITING, READY, READING} buf_st_e;
    typedef enum logic {W_IDLE, W_ACTIVE} wr_st_e;
    typedef enum logic {R_NONE, R_HOLD} rd_st_e;

    localparam logic [ADDR_W-1:0] ADDR1 = BASE_ADDR + BUF_STRIDE;
    localparam logic [ADDR_W-1:0] ADDR2 = ADDR1 + BUF_STRIDE;

    function automatic logic [ADDR_W-1:0] f_addr(input logic [1:0] idx);
        case (idx)
            2'd1:    f_addr = ADDR1;
            2'd2:    f_addr = ADDR2;
            default: f_addr = BASE_ADDR;
        endcase
    endfunction

    buf_st_e           r_st [0:2];
    wr_st_e            r_wstate;
    rd_st_e            r_rstate;
    logic [1:0]        r_wr_idx;
    logic [1:0]        r_rd_idx;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [ADDR_W-1:0] r_rd_addr;
    logic              r_wr_go;
    logic [15:0]       r_drop_cnt;
    logic [15:0]       r_repeat_cnt;

    buf_st_e    w_st [0:2];
    wr_st_e     w_wstate_n;
    rd_st_e     w_rstate_n;
    logic [1:0] w_wr_idx_n;
    logic [1:0] w_rd_idx_n;
    logic       w_go;
    logic       w_drop;
    logic       w_repeat;
    logic [2:0] w_released;
    logic       w_rdy_found;
    logic [1:0] w_rdy_idx;
    logic       w_free_found;
    logic [1:0] w_free_idx;
    logic       w_wr_start;
    logic       w_rd_start;

    assign w_wr_start = bus.enable & bus.wr_frame_start;
    assign w_rd_start = bus.enable & bus.rd_frame_start;

    // Order inside one cycle: write completion, then reader hand-over, then writer allocation.
    always_comb begin
        w_st         = r_st;
        w_wstate_n   = r_wstate;
        w_rstate_n   = r_rstate;
        w_wr_idx_n   = r_wr_idx;
        w_rd_idx_n   = r_rd_idx;
        w_go         = 1'b0;
        w_drop       = 1'b0;
        w_repeat     = 1'b0;
        w_released   = 3'b000;
        w_rdy_found  = 1'b0;
        w_rdy_idx    = 2'd0;
        w_free_found = 1'b0;
        w_free_idx   = 2'd0;

        if (r_wstate == W_ACTIVE && bus.wr_frame_done) begin
            for (int i = 0; i < 3; i++) begin
                if (w_st[i] == READY) begin
                    w_st[i] = FREE;
                    w_drop  = 1'b1;
                end
            end
            w_st[r_wr_idx] = READY;
            w_wstate_n     = W_IDLE;
        end

        for (int i = 0; i < 3; i++) begin
            if (w_st[i] == READY) begin
                w_rdy_found = 1'b1;
                w_rdy_idx   = 2'(i);
            end
        end

        if (w_rd_start) begin
            if (w_rdy_found) begin
                for (int i = 0; i < 3; i++) begin
                    if (w_st[i] == READING) begin
                        w_st[i]       = FREE;
                        w_released[i] = 1'b1;
                    end
                end
                w_st[w_rdy_idx] = READING;
                w_rd_idx_n      = w_rdy_idx;
                w_rstate_n      = R_HOLD;
                w_rdy_found     = 1'b0;
            end else if (r_rstate == R_HOLD) begin
                w_repeat = 1'b1;
            end
        end

        // Descending scan so the lowest free index wins; reader-released buffers wait a cycle.
        for (int i = 2; i >= 0; i--) begin
            if (w_st[i] == FREE && !w_released[i]) begin
                w_free_found = 1'b1;
                w_free_idx   = 2'(i);
            end
        end

        if (w_wr_start) begin
            w_go = 1'b1;
            if (w_wstate_n == W_IDLE) begin
                if (w_free_found) begin
                    w_wr_idx_n = w_free_idx;
                end else begin
                    w_wr_idx_n = w_rdy_idx;
                    w_drop     = 1'b1;
                end
                w_st[w_wr_idx_n] = WRITING;
                w_wstate_n       = W_ACTIVE;
            end
        end
    end

    always_ff @(posedge clk_100 or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) r_st[i] <= FREE;
            r_wstate     <= W_IDLE;
            r_rstate     <= R_NONE;
            r_wr_idx     <= 2'd0;
            r_rd_idx     <= 2'd0;
            r_wr_addr    <= BASE_ADDR;
            r_rd_addr    <= BASE_ADDR;
            r_wr_go      <= 1'b0;
            r_drop_cnt   <= 16'd0;
            r_repeat_cnt <= 16'd0;
        end else begin
            r_st         <= w_st;
            r_wstate     <= w_wstate_n;
            r_rstate     <= w_rstate_n;
            r_wr_idx     <= w_wr_idx_n;
            r_rd_idx     <= w_rd_idx_n;
            r_wr_addr    <= f_addr(w_wr_idx_n);
            r_rd_addr    <= f_addr(w_rd_idx_n);
            r_wr_go      <= w_go;
            if (w_drop && r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
            if (w_repeat && r_repeat_cnt != 16'hFFFF) r_repeat_cnt <= r_repeat_cnt + 16'd1;
        end
    end

    assign bus.wr_go       = r_wr_go;
    assign bus.wr_busy     = (r_wstate == W_ACTIVE);
    assign bus.wr_buf_addr = r_wr_addr;
    assign bus.wr_buf_idx  = r_wr_idx;
    assign bus.rd_valid    = (r_rstate == R_HOLD);
    assign bus.rd_buf_addr = r_rd_addr;
    assign bus.rd_buf_idx  = r_rd_idx;
    assign bus.drop_cnt    = r_drop_cnt;
    assign bus.repeat_cnt  = r_repeat_cnt;
endmodule

// File: tb/tb_frame_buf_scheduler.sv
// Directed bench for frame_buf_scheduler: hand-computed buffer allocation sequences.
module tb_frame_buf_scheduler;
    localparam int ADDR_W = 29;
    localparam logic [31:0] A0 = 32'h0100_0000;
    localparam logic [31:0] A1 = 32'h0120_0000;
    localparam logic [31:0] A2 = 32'h0140_0000;

    logic clk_100 = 1'b0;
    logic reset   = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    frame_buf_scheduler_if #(.ADDR_W(ADDR_W)) bus ();

    frame_buf_scheduler #(.ADDR_W(ADDR_W)) dut (
        .clk_100 (clk_100),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 clk_100 = ~clk_100;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pulse(input logic ws, input logic wd, input logic rs);
        @(negedge clk_100);
        bus.wr_frame_start = ws;
        bus.wr_frame_done  = wd;
        bus.rd_frame_start = rs;
        @(negedge clk_100);
        bus.wr_frame_start = 1'b0;
        bus.wr_frame_done  = 1'b0;
        bus.rd_frame_start = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".wr_go"},    32'(bus.wr_go), 32'd0);
        chk({tag, ".wr_busy"},  32'(bus.wr_busy), 32'd0);
        chk({tag, ".rd_valid"}, 32'(bus.rd_valid), 32'd0);
        chk({tag, ".wr_idx"},   32'(bus.wr_buf_idx), 32'd0);
        chk({tag, ".rd_idx"},   32'(bus.rd_buf_idx), 32'd0);
        chk({tag, ".wr_addr"},  32'(bus.wr_buf_addr), A0);
        chk({tag, ".rd_addr"},  32'(bus.rd_buf_addr), A0);
        chk({tag, ".drop"},     32'(bus.drop_cnt), 32'd0);
        chk({tag, ".repeat"},   32'(bus.repeat_cnt), 32'd0);
    endtask

    initial begin
        bus.enable         = 1'b1;
        bus.wr_frame_start = 1'b0;
        bus.wr_frame_done  = 1'b0;
        bus.rd_frame_start = 1'b0;
        repeat (2) @(negedge clk_100);
        chk_reset_vals("rst");
        reset = 1'b0;

        // Read with nothing ever written: no effect
        pulse(0, 0, 1);
        chk("rnone.valid", 32'(bus.rd_valid), 0);
        chk("rnone.rep",   32'(bus.repeat_cnt), 0);

        // First frame into buffer 0, then read it
        pulse(1, 0, 0);
        chk("t1.go",   32'(bus.wr_go), 1);
        chk("t1.idx",  32'(bus.wr_buf_idx), 0);
        chk("t1.addr", 32'(bus.wr_buf_addr), A0);
        chk("t1.busy", 32'(bus.wr_busy), 1);
        pulse(0, 1, 0);
        chk("t1.busy_done", 32'(bus.wr_busy), 0);
        chk("t1.go_low",    32'(bus.wr_go), 0);
        pulse(0, 0, 1);
        chk("t1.rvalid", 32'(bus.rd_valid), 1);
        chk("t1.ridx",   32'(bus.rd_buf_idx), 0);
        chk("t1.raddr",  32'(bus.rd_buf_addr), A0);

        // Repeat read: buffer 0 kept
        pulse(0, 0, 1);
        chk("t3.ridx", 32'(bus.rd_buf_idx), 0);
        chk("t3.rep",  32'(bus.repeat_cnt), 1);

        // Three frames, no reads, buffer 0 held by reader: 1, 2, 1
        pulse(1, 0, 0);
        chk("t2.f1idx",  32'(bus.wr_buf_idx), 1);
        chk("t2.f1addr", 32'(bus.wr_buf_addr), A1);
        pulse(0, 1, 0);
        pulse(1, 0, 0);
        chk("t2.f2idx",  32'(bus.wr_buf_idx), 2);
        chk("t2.f2addr", 32'(bus.wr_buf_addr), A2);
        pulse(0, 1, 0);
        chk("t2.drop1",  32'(bus.drop_cnt), 1);
        pulse(1, 0, 0);
        chk("t2.f3idx",  32'(bus.wr_buf_idx), 1);
        pulse(0, 1, 0);
        chk("t2.drop2",  32'(bus.drop_cnt), 2);
        pulse(0, 0, 1);
        chk("t2.ridx",   32'(bus.rd_buf_idx), 1);
        chk("t2.raddr",  32'(bus.rd_buf_addr), A1);
        chk("t2.rep",    32'(bus.repeat_cnt), 1);

        // Done and read together: reader takes the fresh buffer 2, frees buffer 1
        pulse(1, 0, 0);
        chk("t4.a_idx", 32'(bus.wr_buf_idx), 0);
        pulse(0, 1, 0);
        pulse(1, 0, 0);
        chk("t4.b_idx", 32'(bus.wr_buf_idx), 2);
        pulse(0, 1, 1);
        chk("t4.ridx",  32'(bus.rd_buf_idx), 2);
        chk("t4.raddr", 32'(bus.rd_buf_addr), A2);
        chk("t4.drop",  32'(bus.drop_cnt), 3);
        pulse(1, 0, 0);
        chk("t4.c_idx", 32'(bus.wr_buf_idx), 0);
        pulse(0, 1, 0);
        pulse(1, 0, 0);
        chk("t4.freed", 32'(bus.wr_buf_idx), 1);
        chk("t4.drop_keep", 32'(bus.drop_cnt), 3);
        pulse(0, 1, 0);
        chk("t4.drop4", 32'(bus.drop_cnt), 4);

        // Aborted frame: same buffer, second wr_go, then reset mid-frame
        pulse(1, 0, 0);
        chk("t5.go1",  32'(bus.wr_go), 1);
        chk("t5.idx1", 32'(bus.wr_buf_idx), 0);
        @(negedge clk_100);
        chk("t5.gap",  32'(bus.wr_go), 0);
        pulse(1, 0, 0);
        chk("t5.go2",  32'(bus.wr_go), 1);
        chk("t5.idx2", 32'(bus.wr_buf_idx), 0);
        chk("t5.drop", 32'(bus.drop_cnt), 4);
        bus.wr_frame_start = 1'b1;
        @(negedge clk_100);
        reset = 1'b1;
        #1;
        chk_reset_vals("t5.rst");
        @(negedge clk_100);
        chk("t5.rst_go", 32'(bus.wr_go), 0);
        bus.wr_frame_start = 1'b0;
        reset = 1'b0;

        // enable=0: starts ignored, done still honoured
        bus.enable = 1'b0;
        pulse(1, 0, 0);
        chk("t6.en0_go",   32'(bus.wr_go), 0);
        chk("t6.en0_busy", 32'(bus.wr_busy), 0);
        bus.enable = 1'b1;
        pulse(1, 0, 0);
        chk("t6.busy", 32'(bus.wr_busy), 1);
        bus.enable = 1'b0;
        pulse(0, 1, 0);
        chk("t6.done_en0", 32'(bus.wr_busy), 0);
        pulse(0, 0, 1);
        chk("t6.rd_en0", 32'(bus.rd_valid), 0);
        bus.enable = 1'b1;
        pulse(0, 0, 1);
        chk("t6.rd_en1", 32'(bus.rd_valid), 1);
        chk("t6.ridx",   32'(bus.rd_buf_idx), 0);

        // Drop counter saturation: start+done every cycle drops one frame per cycle after two
        @(negedge clk_100);
        reset = 1'b1;
        @(negedge clk_100);
        reset = 1'b0;
        bus.wr_frame_start = 1'b1;
        bus.wr_frame_done  = 1'b1;
        repeat (102) @(negedge clk_100);
        chk("t6.drop100", 32'(bus.drop_cnt), 100);
        repeat (65440) @(negedge clk_100);
        chk("t6.drop_sat", 32'(bus.drop_cnt), 32'h0000_FFFF);
        repeat (5) @(negedge clk_100);
        chk("t6.drop_hold", 32'(bus.drop_cnt), 32'h0000_FFFF);
        bus.wr_frame_start = 1'b0;
        bus.wr_frame_done  = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
